// File: rtl/commit_trace_buffer_pkg.sv
// Shared encodings for the commit trace buffer: record kinds, control states and record packing layout.
// Records are packed MSB-first in field-index order, so F_KIND occupies the top bits and F_CYCLE the bottom.
package commit_trace_buffer_pkg;

    localparam int KIND_W = 3;

    typedef enum logic [KIND_W-1:0] {
        NOP_BR = 3'd0,
        REG    = 3'd1,
        ST     = 3'd2,
        LD     = 3'd3,
        STU    = 3'd4,
        HALT   = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int F_KIND     = 0;
    localparam int F_PC       = 1;
    localparam int F_INST     = 2;
    localparam int F_REG      = 3;
    localparam int F_WDATA    = 4;
    localparam int F_ADDR     = 5;
    localparam int F_MDATA    = 6;
    localparam int F_INUM     = 7;
    localparam int F_CYCLE    = 8;
    localparam int NUM_FIELDS = 9;

    function automatic int fieldWidth(input int f, input int dataW, input int regW, input int cntW);
        case (f)
            F_KIND:          return KIND_W;
            F_REG:           return regW;
            F_INUM, F_CYCLE: return cntW;
            default:         return dataW;
        endcase
    endfunction

    function automatic int fieldLsb(input int f, input int dataW, input int regW, input int cntW);
        int lsb = 0;
        for (int i = f + 1; i < NUM_FIELDS; i++) begin
            lsb += fieldWidth(i, dataW, regW, cntW);
        end
        return lsb;
    endfunction

    function automatic int recWidth(input int dataW, input int regW, input int cntW);
        return fieldLsb(F_KIND, dataW, regW, cntW) + KIND_W;
    endfunction

    // First matching rule wins: a HALT is always a HALT, whatever else it writes.
    function automatic kind_e classify(input logic isHalt, input logic regWr,
                                       input logic memRd, input logic memWr);
        if (isHalt)               return HALT;
        else if (regWr && memWr)  return STU;
        else if (regWr && memRd)  return LD;
        else if (regWr)           return REG;
        else if (memWr)           return ST;
        else                      return NOP_BR;
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit-side and trace-sink-side signals of the trace buffer; slave is the buffer, master is pipeline plus sink.
interface commit_trace_buffer_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 32
);
    import commit_trace_buffer_pkg::*;

    logic              commit_valid;
    logic [DATA_W-1:0] commit_pc;
    logic [DATA_W-1:0] commit_inst;
    logic              reg_write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              halt;
    logic              stall;

    logic              rec_valid;
    logic              rec_ready;
    logic [KIND_W-1:0] rec_kind;
    logic [DATA_W-1:0] rec_pc;
    logic [DATA_W-1:0] rec_inst;
    logic [REG_W-1:0]  rec_reg;
    logic [DATA_W-1:0] rec_wdata;
    logic [DATA_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_mdata;
    logic [CNT_W-1:0]  rec_inum;
    logic [CNT_W-1:0]  rec_cycle;
    logic [7:0]        overflow_cnt;
    logic              done;

    modport master (
        output commit_valid, commit_pc, commit_inst, reg_write, write_reg, write_data,
               mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
        input  stall, rec_valid, rec_kind, rec_pc, rec_inst, rec_reg, rec_wdata,
               rec_addr, rec_mdata, rec_inum, rec_cycle, overflow_cnt, done
    );

    modport slave (
        input  commit_valid, commit_pc, commit_inst, reg_write, write_reg, write_data,
               mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
        output stall, rec_valid, rec_kind, rec_pc, rec_inst, rec_reg, rec_wdata,
               rec_addr, rec_mdata, rec_inum, rec_cycle, overflow_cnt, done
    );

endinterface

// File: rtl/commit_trace_buffer_trace_fifo.sv
// Generic DEPTH x WIDTH FIFO with a registered head; a push is readable one cycle later, never bypassed.
// Latency 1 cycle push-to-head; caller must not push when full (unless popping) nor pop when empty.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wrDat,
    input  logic             pop,
    output logic [WIDTH-1:0] rdDat,
    output logic             full,
    output logic             empty,
    output logic             single
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [AW:0]      rdPtrNxt;

    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign single   = ((wrPtr - rdPtr) == ONE);
    assign rdPtrNxt = pop ? rdPtr + ONE : rdPtr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr[AW-1:0]] <= wrDat;
        end
    end

    // Head register tracks the entry rdPtrNxt will point at; a push landing there is forwarded from wrDat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            rdDat <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + ONE;
            end
            rdPtr <= rdPtrNxt;
            if (push && (rdPtrNxt == wrPtr)) begin
                rdDat <= wrDat;
            end else if (pop) begin
                rdDat <= mem[rdPtrNxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Classifies and stamps retiring instructions, queues the records and drains them to a trace sink; runs a halt-drain.
// Latency 1 cycle commit-to-record; stall = full & ~rec_ready, and commits arriving while stalled are dropped and counted.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    commit_trace_buffer_if.slave  bus
);
    localparam int REC_W     = recWidth(DATA_W, REG_W, CNT_W);
    localparam int LSB_KIND  = fieldLsb(F_KIND,  DATA_W, REG_W, CNT_W);
    localparam int LSB_PC    = fieldLsb(F_PC,    DATA_W, REG_W, CNT_W);
    localparam int LSB_INST  = fieldLsb(F_INST,  DATA_W, REG_W, CNT_W);
    localparam int LSB_REG   = fieldLsb(F_REG,   DATA_W, REG_W, CNT_W);
    localparam int LSB_WDATA = fieldLsb(F_WDATA, DATA_W, REG_W, CNT_W);
    localparam int LSB_ADDR  = fieldLsb(F_ADDR,  DATA_W, REG_W, CNT_W);
    localparam int LSB_MDATA = fieldLsb(F_MDATA, DATA_W, REG_W, CNT_W);
    localparam int LSB_INUM  = fieldLsb(F_INUM,  DATA_W, REG_W, CNT_W);
    localparam int LSB_CYCLE = fieldLsb(F_CYCLE, DATA_W, REG_W, CNT_W);

    state_e           state;
    state_e           stateNxt;
    kind_e            kind;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instCnt;
    logic [7:0]       ovfCnt;
    logic [REC_W-1:0] recIn;
    logic [REC_W-1:0] headDat;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             fifoSingle;
    logic             headVld;
    logic             push;
    logic             pop;
    logic             drop;

    assign kind    = classify(bus.halt, bus.reg_write, bus.mem_read, bus.mem_write);
    assign headVld = !fifoEmpty && (state != DONE);
    assign pop     = headVld && bus.rec_ready;
    assign push    = bus.commit_valid && (state == RUN) && (!fifoFull || pop);
    assign drop    = bus.commit_valid && (state == RUN) && fifoFull && !pop;

    // Fields that carry no meaning for this instruction are zeroed so the sink never sees stale bus values.
    always_comb begin
        recIn = '0;
        recIn[LSB_KIND +: KIND_W] = kind;
        recIn[LSB_PC   +: DATA_W] = bus.commit_pc;
        recIn[LSB_INST +: DATA_W] = bus.commit_inst;
        if (bus.reg_write) begin
            recIn[LSB_REG   +: REG_W]  = bus.write_reg;
            recIn[LSB_WDATA +: DATA_W] = bus.write_data;
        end
        if (bus.mem_read || bus.mem_write) begin
            recIn[LSB_ADDR +: DATA_W] = bus.mem_addr;
        end
        if (bus.mem_write) begin
            recIn[LSB_MDATA +: DATA_W] = bus.mem_data;
        end
        recIn[LSB_INUM  +: CNT_W] = instCnt;
        recIn[LSB_CYCLE +: CNT_W] = cycleCnt;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .wrDat  (recIn),
        .pop    (pop),
        .rdDat  (headDat),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .single (fifoSingle)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= stateNxt;
        end
    end

    // DRAIN accepts no pushes, so popping the last entry means the HALT record has left.
    always_comb begin
        stateNxt = state;
        case (state)
            RUN:     if (push && bus.halt)  stateNxt = DRAIN;
            DRAIN:   if (pop && fifoSingle) stateNxt = DONE;
            DONE:    stateNxt = DONE;
            default: stateNxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycleCnt <= '0;
            instCnt  <= '0;
            ovfCnt   <= '0;
        end else begin
            cycleCnt <= cycleCnt + CNT_W'(1);
            if (push) begin
                instCnt <= instCnt + CNT_W'(1);
            end
            if (drop && (ovfCnt != 8'hFF)) begin
                ovfCnt <= ovfCnt + 8'd1;
            end
        end
    end

    assign bus.stall        = fifoFull && !bus.rec_ready;
    assign bus.rec_valid    = headVld;
    assign bus.rec_kind     = headDat[LSB_KIND  +: KIND_W];
    assign bus.rec_pc       = headDat[LSB_PC    +: DATA_W];
    assign bus.rec_inst     = headDat[LSB_INST  +: DATA_W];
    assign bus.rec_reg      = headDat[LSB_REG   +: REG_W];
    assign bus.rec_wdata    = headDat[LSB_WDATA +: DATA_W];
    assign bus.rec_addr     = headDat[LSB_ADDR  +: DATA_W];
    assign bus.rec_mdata    = headDat[LSB_MDATA +: DATA_W];
    assign bus.rec_inum     = headDat[LSB_INUM  +: CNT_W];
    assign bus.rec_cycle    = headDat[LSB_CYCLE +: CNT_W];
    assign bus.overflow_cnt = ovfCnt;
    assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: classification, stamping, backpressure, overflow, halt-drain and reset.
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    commit_trace_buffer_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    commit_trace_buffer #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] pc, input logic [15:0] inst, input logic rw,
                         input logic [2:0] wr, input logic [15:0] wd, input logic mr,
                         input logic mw, input logic [15:0] ad, input logic [15:0] md,
                         input logic h);
        bus.commit_valid = 1'b1;
        bus.commit_pc    = pc;
        bus.commit_inst  = inst;
        bus.reg_write    = rw;
        bus.write_reg    = wr;
        bus.write_data   = wd;
        bus.mem_read     = mr;
        bus.mem_write    = mw;
        bus.mem_addr     = ad;
        bus.mem_data     = md;
        bus.halt         = h;
    endtask

    task automatic idle();
        drive(16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        bus.commit_valid = 1'b0;
    endtask

    task automatic checkHead(input string tag, input logic [2:0] kind, input logic [15:0] pc,
                             input logic [2:0] rg, input logic [15:0] wd, input logic [15:0] ad,
                             input logic [15:0] md, input logic [31:0] inum);
        check({tag, "_valid"}, bus.rec_valid, 1);
        check({tag, "_kind"},  bus.rec_kind,  kind);
        check({tag, "_pc"},    bus.rec_pc,    pc);
        check({tag, "_reg"},   bus.rec_reg,   rg);
        check({tag, "_wdata"}, bus.rec_wdata, wd);
        check({tag, "_addr"},  bus.rec_addr,  ad);
        check({tag, "_mdata"}, bus.rec_mdata, md);
        check({tag, "_inum"},  bus.rec_inum,  inum);
    endtask

    initial begin
        idle();
        bus.rec_ready = 1'b0;

        // Reset state
        tick();
        check("rst_valid", bus.rec_valid, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_done",  bus.done, 0);
        check("rst_ovf",   bus.overflow_cnt, 0);
        check("rst_inum",  bus.rec_inum, 0);
        check("rst_kind",  bus.rec_kind, 0);
        tick();

        // ADDI / ST / BEQZ streamed with the sink always ready
        rst = 1'b1;
        bus.rec_ready = 1'b1;
        drive(16'h0000, 16'h1105, 1, 3'd2, 16'h0005, 0, 0, 16'h7777, 16'h6666, 0);
        #1;
        check("nobypass_valid", bus.rec_valid, 0);
        tick();
        checkHead("addi", REG, 16'h0000, 3'd2, 16'h0005, 16'h0, 16'h0, 0);
        check("addi_cycle", bus.rec_cycle, 0);
        drive(16'h0002, 16'h2010, 0, 3'd5, 16'h9999, 0, 1, 16'h0010, 16'h1234, 0);
        tick();
        checkHead("st", ST, 16'h0002, 3'd0, 16'h0, 16'h0010, 16'h1234, 1);
        check("st_cycle", bus.rec_cycle, 1);
        drive(16'h0004, 16'h3004, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        tick();
        checkHead("beqz", NOP_BR, 16'h0004, 3'd0, 16'h0, 16'h0, 16'h0, 2);
        check("beqz_cycle", bus.rec_cycle, 2);
        idle();
        tick();
        check("t1_empty", bus.rec_valid, 0);

        // Fill to DEPTH with the sink stalled; the 9th is held then accepted alongside a pop
        bus.rec_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(16'h0100 + 16'(2 * i), 16'h4000 + 16'(i), 1, 3'(i), 16'(i), 0, 0, 16'h0, 16'h0, 0);
            tick();
        end
        drive(16'h0110, 16'h4008, 1, 3'd0, 16'h0008, 0, 0, 16'h0, 16'h0, 0);
        check("full_stall", bus.stall, 1);
        check("full_head_inum", bus.rec_inum, 3);
        check("full_ovf", bus.overflow_cnt, 0);
        bus.rec_ready = 1'b1;
        #1;
        check("full_ready_stall", bus.stall, 0);
        tick();
        idle();
        bus.rec_ready = 1'b0;
        #1;
        check("still_full_stall", bus.stall, 1);
        check("pushpop_head_inum", bus.rec_inum, 4);
        check("pushpop_ovf", bus.overflow_cnt, 0);

        // Forced commit while stalled is dropped; numbering continues without a gap
        drive(16'h0200, 16'h4100, 1, 3'd1, 16'hDEAD, 0, 0, 16'h0, 16'h0, 0);
        tick();
        idle();
        check("drop_ovf", bus.overflow_cnt, 1);
        check("drop_head_inum", bus.rec_inum, 4);
        drive(16'h0202, 16'h4200, 1, 3'd2, 16'h0077, 0, 0, 16'h0, 16'h0, 0);
        bus.rec_ready = 1'b1;
        tick();
        idle();
        for (int k = 5; k <= 12; k++) begin
            check("drain_inum", bus.rec_inum, k);
            check("drain_pc", bus.rec_pc, (k == 12) ? 16'h0202 : 16'h0100 + 16'(2 * (k - 3)));
            tick();
        end
        check("drain_empty", bus.rec_valid, 0);

        // LD and STU field handling
        bus.rec_ready = 1'b0;
        drive(16'h0006, 16'h5320, 1, 3'd3, 16'hBEEF, 1, 0, 16'h0020, 16'h5555, 0);
        tick();
        drive(16'h0008, 16'h6430, 1, 3'd4, 16'h0031, 0, 1, 16'h0030, 16'h00AA, 0);
        tick();
        idle();
        checkHead("ld", LD, 16'h0006, 3'd3, 16'hBEEF, 16'h0020, 16'h0, 13);
        bus.rec_ready = 1'b1;
        tick();
        checkHead("stu", STU, 16'h0008, 3'd4, 16'h0031, 16'h0030, 16'h00AA, 14);
        tick();
        check("ldstu_empty", bus.rec_valid, 0);

        // HALT behind two queued records; later commits ignored; done after last pop
        bus.rec_ready = 1'b0;
        drive(16'h0040, 16'h7001, 1, 3'd5, 16'h0001, 0, 0, 16'h0, 16'h0, 0);
        tick();
        drive(16'h0042, 16'h7002, 1, 3'd6, 16'h0002, 0, 0, 16'h0, 16'h0, 0);
        tick();
        drive(16'h000C, 16'hF000, 1, 3'd1, 16'h0042, 0, 1, 16'h0050, 16'h0011, 1);
        tick();
        drive(16'h0050, 16'h7003, 1, 3'd7, 16'h0003, 0, 0, 16'h0, 16'h0, 0);
        tick();
        tick();
        check("drain_ignore_ovf", bus.overflow_cnt, 1);
        check("drain_done0", bus.done, 0);
        check("drain_head0", bus.rec_inum, 15);
        bus.rec_ready = 1'b1;
        tick();
        check("drain_head1", bus.rec_inum, 16);
        tick();
        checkHead("halt", HALT, 16'h000C, 3'd1, 16'h0042, 16'h0050, 16'h0011, 17);
        check("halt_done0", bus.done, 0);
        tick();
        check("done_set", bus.done, 1);
        check("done_valid", bus.rec_valid, 0);
        check("done_stall", bus.stall, 0);
        idle();
        tick();
        tick();
        check("done_hold", bus.done, 1);
        check("done_hold_valid", bus.rec_valid, 0);

        // Reset out of DONE, then reset again in the middle of a drain
        rst = 1'b0;
        #1;
        check("rst_done_clear", bus.done, 0);
        rst = 1'b1;
        bus.rec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'h0080 + 16'(2 * i), 16'h8000, 1, 3'd1, 16'(i), 0, 0, 16'h0, 16'h0, 0);
            tick();
        end
        drive(16'h0086, 16'hF000, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        tick();
        idle();
        tick();
        check("pre_rst_valid", bus.rec_valid, 1);
        check("pre_rst_inum", bus.rec_inum, 0);
        rst = 1'b0;
        #1;
        check("midrst_valid", bus.rec_valid, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_ovf", bus.overflow_cnt, 0);
        check("midrst_stall", bus.stall, 0);
        check("midrst_cycle", bus.rec_cycle, 0);
        #1;
        rst = 1'b1;
        drive(16'h0060, 16'h9000, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
        tick();
        idle();
        checkHead("post_rst", NOP_BR, 16'h0060, 3'd0, 16'h0, 16'h0, 16'h0, 0);
        check("post_rst_cycle", bus.rec_cycle, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
